// File: rtl/vga_timing_pipe_if.sv
// Pixel-side bundle of the VGA timing pipe: pixel tick and colour in, counters, syncs and DAC colour out.
// master = timing pipe, slave = video generator / pin side.
interface vga_timing_pipe_if #(
    parameter int CW      = 10,
    parameter int COLOR_W = 8
);
    // pix_en qualifies every transfer: rgb_in is sampled and all state moves only on a vgaclk
    // edge where pix_en is high; there is no backpressure, so the generator must keep pace.
    logic                   pix_en;
    logic [3*COLOR_W-1:0]   rgb_in;
    logic [CW-1:0]          counterH;
    logic [CW-1:0]          counterV;
    logic                   active;
    logic                   line_start;
    logic                   frame_start;
    logic                   hsync;
    logic                   vsync;
    logic                   vga_blank;
    logic                   vga_sync;
    logic [7:0]             r;
    logic [7:0]             g;
    logic [7:0]             b;

    modport master (
        input  pix_en, rgb_in,
        output counterH, counterV, active, line_start, frame_start,
        output hsync, vsync, vga_blank, vga_sync, r, g, b
    );

    modport slave (
        output pix_en, rgb_in,
        input  counterH, counterV, active, line_start, frame_start,
        input  hsync, vsync, vga_blank, vga_sync, r, g, b
    );
endinterface

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator; syncs and blank are delayed to line up with the
// generator's registered colour, and colour channels are widened to the 8-bit DAC.
module vga_timing_pipe #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int COLOR_W  = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic               vgaclk,
    input  logic               rst_n,
    vga_timing_pipe_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D       = PIPE_LAT + 1;

    // Compare in CW+1 bits so a sync end equal to 2**CW stays representable.
    localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] H_SS   = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SE   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_SS   = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SE   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > (1 << CW)) begin : g_bad_htotal
            $error("vga_timing_pipe: H_TOTAL exceeds 2**CW");
        end
        if (V_TOTAL > (1 << CW)) begin : g_bad_vtotal
            $error("vga_timing_pipe: V_TOTAL exceeds 2**CW");
        end
        if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
            $error("vga_timing_pipe: sync width must be at least 1");
        end
        if (COLOR_W < 1 || COLOR_W > 8) begin : g_bad_color
            $error("vga_timing_pipe: COLOR_W must be 1..8");
        end
        if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_lat
            $error("vga_timing_pipe: PIPE_LAT must be 0..7");
        end
    endgenerate

    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW:0]   h_ext, v_ext;
    logic          hs_raw, vs_raw, active_c;
    logic [D-1:0]  hs_q, vs_q, bl_q;
    logic [D:0]    bl_taps;
    logic          blank_tap;
    logic [7:0]    r_q, g_q, b_q;

    assign h_ext    = {1'b0, h_cnt};
    assign v_ext    = {1'b0, v_cnt};
    assign active_c = (h_ext < H_VIS) && (v_ext < V_VIS);
    assign hs_raw   = (h_ext >= H_SS && h_ext < H_SE) ? HS_POL : ~HS_POL;
    assign vs_raw   = (v_ext >= V_SS && v_ext < V_SE) ? VS_POL : ~VS_POL;

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.pix_en) begin
            if (h_ext == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_ext == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Tap k is the blank value k ticks old; tap PIPE_LAT matches the colour now arriving on rgb_in.
    assign bl_taps   = {bl_q, active_c};
    assign blank_tap = bl_taps[PIPE_LAT];

    function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_W-1-(i % COLOR_W)];
        return e;
    endfunction

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= {D{~HS_POL}};
            vs_q <= {D{~VS_POL}};
            bl_q <= '0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else if (bus.pix_en) begin
            hs_q <= D'({hs_q, hs_raw});
            vs_q <= D'({vs_q, vs_raw});
            bl_q <= D'({bl_q, active_c});
            if (blank_tap) begin
                r_q <= expand(bus.rgb_in[COLOR_W-1:0]);
                g_q <= expand(bus.rgb_in[2*COLOR_W-1:COLOR_W]);
                b_q <= expand(bus.rgb_in[3*COLOR_W-1:2*COLOR_W]);
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    assign bus.counterH    = h_cnt;
    assign bus.counterV    = v_cnt;
    assign bus.active      = active_c;
    assign bus.line_start  = bus.pix_en && (h_cnt == '0);
    assign bus.frame_start = bus.pix_en && (h_cnt == '0) && (v_cnt == '0);
    assign bus.hsync       = hs_q[D-1];
    assign bus.vsync       = vs_q[D-1];
    assign bus.vga_blank   = bl_q[D-1];
    assign bus.vga_sync    = 1'b0;
    assign bus.r           = r_q;
    assign bus.g           = g_q;
    assign bus.b           = b_q;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe on a small 28x17 raster with PIPE_LAT=3, COLOR_W=4 and mixed sync polarity,
// compared against a position/history model of the timing rules.
module tb_vga_timing_pipe;
  localparam int HA = 16, HF = 4, HSW = 3, HB = 5;
  localparam int VA = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int CW = 6;
  localparam int CWD = 4;
  localparam int PL = 3;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;

  // clock / reset
  logic vgaclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 vgaclk = ~vgaclk;

  vga_timing_pipe_if #(.CW(CW), .COLOR_W(CWD)) vif ();

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .COLOR_W(CWD), .PIPE_LAT(PL)
  ) dut (
    .vgaclk(vgaclk),
    .rst_n(rst_n),
    .bus(vif)
  );

  int n_vec;
  int n_err;

  // reference model: raster position plus per-tick history of raw sync/blank
  int mh, mv;
  logic hs_h[$];
  logic vs_h[$];
  logic bl_h[$];
  logic [7:0] er, eg, eb;
  logic cur_pe;
  logic [11:0] cur_rgb;

  function automatic logic hs_raw_at(int h);
    return (h >= HA + HF && h < HA + HF + HSW) ? HS_POL : ~HS_POL;
  endfunction

  function automatic logic vs_raw_at(int v);
    return (v >= VA + VF && v < VA + VF + VSW) ? VS_POL : ~VS_POL;
  endfunction

  function automatic logic [7:0] widen(logic [3:0] c);
    return 8'(c) * 8'd17;
  endfunction

  function automatic int tap_idx();
    return bl_h.size() - 1 - PL;
  endfunction

  function automatic logic exp_hs();
    return (tap_idx() >= 0) ? hs_h[tap_idx()] : ~HS_POL;
  endfunction

  function automatic logic exp_vs();
    return (tap_idx() >= 0) ? vs_h[tap_idx()] : ~VS_POL;
  endfunction

  function automatic logic exp_bl();
    return (tap_idx() >= 0) ? bl_h[tap_idx()] : 1'b0;
  endfunction

  function automatic logic [14:0] exp_comb();
    return {CW'(mh), CW'(mv), (mh < HA && mv < VA), (cur_pe && mh == 0), (cur_pe && mh == 0 && mv == 0)};
  endfunction

  function automatic logic [27:0] exp_regs();
    return {exp_hs(), exp_vs(), exp_bl(), er, eg, eb, 1'b0};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    hs_h.delete();
    vs_h.delete();
    bl_h.delete();
    er = '0;
    eg = '0;
    eb = '0;
  endtask

  task automatic model_tick(input logic [11:0] rgb);
    hs_h.push_back(hs_raw_at(mh));
    vs_h.push_back(vs_raw_at(mv));
    bl_h.push_back(mh < HA && mv < VA);
    if (tap_idx() >= 0 && bl_h[tap_idx()]) begin
      er = widen(rgb[3:0]);
      eg = widen(rgb[7:4]);
      eb = widen(rgb[11:8]);
    end else begin
      er = '0;
      eg = '0;
      eb = '0;
    end
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    while (bl_h.size() > 8) begin
      void'(hs_h.pop_front());
      void'(vs_h.pop_front());
      void'(bl_h.pop_front());
    end
  endtask

  // driver tasks
  task automatic set_inputs(input logic pe, input logic [11:0] rgb);
    vif.pix_en = pe;
    vif.rgb_in = rgb;
    cur_pe = pe;
    cur_rgb = rgb;
    #1;
  endtask

  task automatic clk_step();
    @(posedge vgaclk);
    if (cur_pe) model_tick(cur_rgb);
    @(negedge vgaclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge vgaclk);
    set_inputs(1'b0, 12'h000);
    n_vec++;
    if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
      n_err++;
      $display("FAIL reset_comb: got %h want %h",
               {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
    end
    n_vec++;
    if ({vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync} !== exp_regs()) begin
      n_err++;
      $display("FAIL reset_regs: got %h want %h",
               {vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync}, exp_regs());
    end
    rst_n = 1'b1;
    set_inputs(1'b1, 12'($urandom));
    n_vec++;
    if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
      n_err++;
      $display("FAIL first_tick_comb: got %h want %h",
               {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
    end
    clk_step();
  endtask

  task automatic test_full_frame();
    int fs_seen, last_fs, period, hrun, vrun;
    fs_seen = 0; last_fs = 0; period = 0; hrun = 0; vrun = 0;
    for (int cyc = 0; cyc < 2 * HT * VT + 20; cyc++) begin
      set_inputs(1'b1, 12'($urandom));
      n_vec++;
      if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
        n_err++;
        $display("FAIL frame_comb @%0d: got %h want %h", cyc,
                 {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
      end
      n_vec++;
      if ({vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync} !== exp_regs()) begin
        n_err++;
        $display("FAIL frame_regs @%0d: got %h want %h", cyc,
                 {vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync}, exp_regs());
      end
      if (vif.frame_start === 1'b1) begin
        if (fs_seen > 0 && period == 0) period = cyc - last_fs;
        fs_seen++;
        last_fs = cyc;
      end
      if (vif.hsync === HS_POL) hrun++;
      else if (hrun > 0) begin
        n_vec++;
        if (hrun != HSW) begin
          n_err++;
          $display("FAIL hsync_width: got %0d ticks want %0d", hrun, HSW);
        end
        hrun = 0;
      end
      if (vif.vsync === VS_POL) vrun++;
      else if (vrun > 0) begin
        n_vec++;
        if (vrun != VSW * HT) begin
          n_err++;
          $display("FAIL vsync_width: got %0d ticks want %0d", vrun, VSW * HT);
        end
        vrun = 0;
      end
      clk_step();
    end
    n_vec++;
    if (period != HT * VT) begin
      n_err++;
      $display("FAIL frame_period: got %0d cycles want %0d", period, HT * VT);
    end
  endtask

  task automatic test_pix_en_half();
    int fs_seen, last_fs, period;
    fs_seen = 0; last_fs = 0; period = 0;
    for (int cyc = 0; cyc < 4 * HT * VT + 20; cyc++) begin
      set_inputs(cyc[0] == 1'b0, 12'($urandom));
      n_vec++;
      if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
        n_err++;
        $display("FAIL half_comb @%0d: got %h want %h", cyc,
                 {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
      end
      n_vec++;
      if ({vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync} !== exp_regs()) begin
        n_err++;
        $display("FAIL half_regs @%0d: got %h want %h", cyc,
                 {vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync}, exp_regs());
      end
      if (vif.frame_start === 1'b1) begin
        if (fs_seen > 0 && period == 0) period = cyc - last_fs;
        fs_seen++;
        last_fs = cyc;
      end
      clk_step();
    end
    n_vec++;
    if (period != 2 * HT * VT) begin
      n_err++;
      $display("FAIL half_period: got %0d cycles want %0d", period, 2 * HT * VT);
    end
  endtask

  task automatic test_pix_en_random();
    for (int cyc = 0; cyc < 700; cyc++) begin
      set_inputs(1'($urandom_range(0, 1)), 12'($urandom));
      n_vec++;
      if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
        n_err++;
        $display("FAIL rand_comb @%0d: got %h want %h", cyc,
                 {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
      end
      n_vec++;
      if ({vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync} !== exp_regs()) begin
        n_err++;
        $display("FAIL rand_regs @%0d: got %h want %h", cyc,
                 {vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync}, exp_regs());
      end
      clk_step();
    end
  endtask

  task automatic test_porch_ones();
    logic [23:0] want;
    for (int cyc = 0; cyc < HT * VT; cyc++) begin
      set_inputs(1'b1, 12'hFFF);
      want = exp_bl() ? 24'hFFFFFF : 24'h000000;
      n_vec++;
      if ({vif.r, vif.g, vif.b} !== want || vif.vga_blank !== exp_bl()) begin
        n_err++;
        $display("FAIL porch_ones @%0d: got rgb=%h blank=%b want rgb=%h blank=%b", cyc,
                 {vif.r, vif.g, vif.b}, vif.vga_blank, want, exp_bl());
      end
      clk_step();
    end
  endtask

  task automatic test_color_expand();
    for (int cyc = 0; cyc < 3 * HT; cyc++) begin
      set_inputs(1'b1, 12'h3AF);
      if (exp_bl()) begin
        n_vec++;
        if (vif.b !== 8'h33 || vif.g !== 8'hAA || vif.r !== 8'hFF) begin
          n_err++;
          $display("FAIL color_expand @%0d: got b=%h g=%h r=%h want b=33 g=aa r=ff", cyc, vif.b, vif.g, vif.r);
        end
      end
      clk_step();
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2 * HT * VT && !(mh == 10 && mv == 5); i++) begin
      set_inputs(1'b1, 12'($urandom));
      clk_step();
    end
    set_inputs(1'b0, 12'h000);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
      n_err++;
      $display("FAIL midreset_comb: got %h want %h",
               {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
    end
    n_vec++;
    if ({vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync} !== exp_regs()) begin
      n_err++;
      $display("FAIL midreset_regs: got %h want %h",
               {vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync}, exp_regs());
    end
    repeat (3) @(negedge vgaclk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 2 * HT; cyc++) begin
      set_inputs(1'b1, 12'($urandom));
      n_vec++;
      if ({vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start} !== exp_comb()) begin
        n_err++;
        $display("FAIL restart_comb @%0d: got %h want %h", cyc,
                 {vif.counterH, vif.counterV, vif.active, vif.line_start, vif.frame_start}, exp_comb());
      end
      n_vec++;
      if ({vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync} !== exp_regs()) begin
        n_err++;
        $display("FAIL restart_regs @%0d: got %h want %h", cyc,
                 {vif.hsync, vif.vsync, vif.vga_blank, vif.r, vif.g, vif.b, vif.vga_sync}, exp_regs());
      end
      clk_step();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vif.pix_en = 1'b0;
    vif.rgb_in = '0;
    cur_pe = 1'b0;
    cur_rgb = '0;
    model_reset();
    test_reset();
    test_full_frame();
    test_pix_en_half();
    test_pix_en_random();
    test_porch_ones();
    test_color_expand();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
